jk_using_sr: RTL and testbench

//  - Single-bit JK flip-flop built from an SR flip-flop core plus JK-to-SR excitation logic.
//  - Used as a sequential leaf cell (counters, small state registers) and as a flip-flop-conversion reference cell.
//  - Provides true output Qs and complementary output Qs_bar.

---
 rtl/jk_using_sr_pkg.sv | 11 +
 rtl/jk_using_sr_sr_ff.sv | 21 ++
 rtl/jk_using_sr.sv | 24 ++
 tb/tb_jk_using_sr.sv | 75 +++++++
 4 files changed

// File: rtl/jk_using_sr_pkg.sv
// jk_using_sr_pkg: SR and JK input encodings shared by the JK-from-SR flip-flop
package jk_using_sr_pkg;
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_INV  = 2'b11;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;
endpackage

// File: rtl/jk_using_sr_sr_ff.sv
// sr_ff: clocked SR flip-flop with sync active-low reset; S=R=1 holds
module sr_ff
  import jk_using_sr_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Q_bar
);
  logic q;
  always_ff @(posedge clk)
    if (!rst) q <= RESET_VAL;
    else if ({S, R} == SR_SET) q <= 1'b1;
    else if ({S, R} == SR_RST) q <= 1'b0;
  assign Q = q;
  assign Q_bar = ~q;
endmodule

// File: rtl/jk_using_sr.sv
// jk_using_sr: JK flip-flop made from an SR core plus JK-to-SR excitation logic
module jk_using_sr #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Qs,
  output logic Qs_bar
);
  logic s, r;
  // gating with the current state keeps S and R mutually exclusive, so J=K=1 toggles
  assign s = J & ~Qs;
  assign r = K & Qs;
  sr_ff #(.RESET_VAL(RESET_VAL)) u_sr (
    .clk(clk),
    .rst(rst),
    .S(s),
    .R(r),
    .Q(Qs),
    .Q_bar(Qs_bar)
  );
endmodule

// File: tb/tb_jk_using_sr.sv
// tb_jk_using_sr: table-driven and scoreboarded check of jk_using_sr for both reset values
module tb_jk_using_sr;
  logic clk = 1'b0, rst = 1'b1, J = 1'b0, K = 1'b0;
  logic q0, qb0, q1, qb1;
  logic m0 = 1'b0, m1 = 1'b1;
  logic sb[$];
  int passed = 0, total = 0;
  typedef struct {logic r; logic j; logic k; logic e; string nm;} vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  jk_using_sr #(.RESET_VAL(1'b0)) dut0 (.clk(clk), .rst(rst), .J(J), .K(K), .Qs(q0), .Qs_bar(qb0));
  jk_using_sr #(.RESET_VAL(1'b1)) dut1 (.clk(clk), .rst(rst), .J(J), .K(K), .Qs(q1), .Qs_bar(qb1));
  function automatic logic jk(input logic q, input logic j, input logic k);
    return (j && k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
  endfunction
  task automatic check(input string nm, input logic act, input logic req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b, want %b", nm, act, req);
  endtask
  task automatic step(input logic r, input logic j, input logic k, input logic e, input string nm, input bit glitch);
    @(negedge clk);
    rst = r; J = j; K = k;
    if (glitch) begin
      #1 J = 1'b1;
      #2 J = 1'b0;
    end
    sb.push_back(e);
    m0 = !r ? 1'b0 : jk(m0, j, k);
    m1 = !r ? 1'b1 : jk(m1, j, k);
    @(posedge clk);
    #1;
    check({nm, " q"}, q0, sb.pop_front());
    check({nm, " model0"}, q0, m0);
    check({nm, " qbar0"}, qb0, ~m0);
    check({nm, " model1"}, q1, m1);
    check({nm, " qbar1"}, qb1, ~m1);
  endtask
  initial begin
    logic rj, rk, rr, e;
    tbl = '{
      '{1'b0, 1'b0, 1'b0, 1'b0, "reset"},
      '{1'b0, 1'b1, 1'b0, 1'b0, "reset_prio"},
      '{1'b1, 1'b0, 1'b0, 1'b0, "hold0"},
      '{1'b1, 1'b0, 1'b1, 1'b0, "clr0"},
      '{1'b1, 1'b0, 1'b0, 1'b0, "hold0b"},
      '{1'b1, 1'b1, 1'b0, 1'b1, "set"},
      '{1'b1, 1'b0, 1'b0, 1'b1, "memory"},
      '{1'b1, 1'b1, 1'b1, 1'b0, "toggle"},
      '{1'b1, 1'b1, 1'b1, 1'b1, "tog1"},
      '{1'b1, 1'b1, 1'b1, 1'b0, "tog2"},
      '{1'b1, 1'b1, 1'b1, 1'b1, "tog3"},
      '{1'b1, 1'b1, 1'b1, 1'b0, "tog4"},
      '{1'b1, 1'b1, 1'b1, 1'b1, "tog5"},
      '{1'b1, 1'b1, 1'b1, 1'b0, "tog6"},
      '{1'b1, 1'b1, 1'b1, 1'b1, "tog_up"},
      '{1'b0, 1'b1, 1'b1, 1'b0, "mid_reset"},
      '{1'b1, 1'b1, 1'b1, 1'b1, "resume"},
      '{1'b1, 1'b0, 1'b1, 1'b0, "clr_again"}
    };
    foreach (tbl[i]) step(tbl[i].r, tbl[i].j, tbl[i].k, tbl[i].e, tbl[i].nm, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "glitch_j", 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, "set_after_glitch", 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, "glitch_at1", 1'b1);
    for (int i = 0; i < 40; i++) begin
      rj = 1'($urandom_range(0, 1));
      rk = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 7) != 0);
      e = !rr ? 1'b0 : jk(m0, rj, rk);
      step(rr, rj, rk, e, "random", 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
